// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm clock datapath.
package alarm_pkg;

  typedef logic [7:0] bcd_t;

  localparam bcd_t SEC_MAX  = 8'h59;
  localparam bcd_t MIN_MAX  = 8'h59;
  localparam bcd_t HOUR_MAX = 8'h23;

  // Next packed-BCD value, wrapping to 00 after max.
  function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t max);
    if (v == max) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after MAX_BCD.
module bcd_mod_counter
  import alarm_pkg::*;
#(
  parameter bcd_t MAX_BCD = SEC_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output bcd_t out,
  output logic carry
);

  bcd_t value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 8'h00;
    end else if (clr) begin
      value_q <= 8'h00;
    end else if (en) begin
      value_q <= bcd_inc(value_q, MAX_BCD);
    end
  end

  assign out   = value_q;
  assign carry = en && (value_q == MAX_BCD);

endmodule

// File: rtl/time_keeper.sv
// Time-of-day base: 1 Hz prescaler, BCD hh:mm:ss chain and set-mode button handling.
module time_keeper
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       clr_sec,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam int unsigned CntW = $clog2(CLK_HZ);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            inc_hour_q, inc_min_q;
  logic            hour_edge, min_edge;
  logic            sec_en, min_en, hour_en, sec_clr;
  logic            sec_carry, min_carry, hour_carry;
  logic            sec_pulse_q, day_wrap_q;

  // set_mode wins over a coincident tick: no advance on the mode-change edge.
  assign tick = !set_mode && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (set_mode || tick) begin
      cnt_d = '0;
    end
  end

  assign hour_edge = inc_hour && !inc_hour_q;
  assign min_edge  = inc_min && !inc_min_q;

  // Run mode ripples carries; set mode drives each field from its own button.
  assign sec_en  = tick;
  assign sec_clr = set_mode && clr_sec;
  assign min_en  = set_mode ? min_edge : sec_carry;
  assign hour_en = set_mode ? hour_edge : min_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      inc_hour_q  <= 1'b0;
      inc_min_q   <= 1'b0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      inc_hour_q  <= inc_hour;
      inc_min_q   <= inc_min;
      sec_pulse_q <= tick;
      day_wrap_q  <= tick && hour_carry;
    end
  end

  bcd_mod_counter #(
    .MAX_BCD (SEC_MAX)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .clr   (sec_clr),
    .out   (seconds_bcd),
    .carry (sec_carry)
  );

  bcd_mod_counter #(
    .MAX_BCD (MIN_MAX)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_en),
    .clr   (1'b0),
    .out   (minutes_bcd),
    .carry (min_carry)
  );

  bcd_mod_counter #(
    .MAX_BCD (HOUR_MAX)
  ) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hour_en),
    .clr   (1'b0),
    .out   (hours_bcd),
    .carry (hour_carry)
  );

  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed table, corner sequences and random run.
module tb_time_keeper;

  localparam int unsigned HZ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_hour = 1'b0;
  logic       inc_min = 1'b0;
  logic       clr_sec = 1'b0;
  logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
  logic       sec_pulse, day_wrap;

  always #5 clk = ~clk;

  time_keeper #(
    .CLK_HZ (HZ)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_mode    (set_mode),
    .inc_hour    (inc_hour),
    .inc_min     (inc_min),
    .clr_sec     (clr_sec),
    .hours_bcd   (hours_bcd),
    .minutes_bcd (minutes_bcd),
    .seconds_bcd (seconds_bcd),
    .sec_pulse   (sec_pulse),
    .day_wrap    (day_wrap)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time of day as plain integers.
  int m_h, m_m, m_s, m_pc;
  bit m_ihq, m_imq, m_pulse, m_wrap;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_pc = 0;
    m_ihq = 0; m_imq = 0; m_pulse = 0; m_wrap = 0;
  endtask

  task automatic model_clock();
    int t;
    m_pulse = 0;
    m_wrap  = 0;
    if (!set_mode) begin
      if (m_pc == HZ - 1) begin
        m_pc = 0;
        t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = t / 3600;
        m_m = (t / 60) % 60;
        m_s = t % 60;
        m_pulse = 1;
        m_wrap  = (t == 0);
      end else begin
        m_pc++;
      end
    end else begin
      m_pc = 0;
      if (inc_hour && !m_ihq) m_h = (m_h + 1) % 24;
      if (inc_min && !m_imq) m_m = (m_m + 1) % 60;
      if (clr_sec) m_s = 0;
    end
    m_ihq = inc_hour;
    m_imq = inc_min;
  endtask

  task automatic check_model();
    check("hours", hours_bcd, to_bcd(m_h));
    check("minutes", minutes_bcd, to_bcd(m_m));
    check("seconds", seconds_bcd, to_bcd(m_s));
    check("sec_pulse", {7'd0, sec_pulse}, {7'd0, m_pulse});
    check("day_wrap", {7'd0, day_wrap}, {7'd0, m_wrap});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clock();
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input bit sm, input bit ih, input bit im, input bit cs);
    set_mode = sm; inc_hour = ih; inc_min = im; clr_sec = cs;
  endtask

  task automatic pulse_btn(input bit ih, input bit im, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, ih, im, 0);
      step();
      drive(1, 0, 0, 0);
      step();
    end
  endtask

  typedef struct {
    string      name;
    bit         sm, ih, im, cs;
    int         cyc;
    logic [7:0] eh, em, es;
    bit         ep;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{"run4",          0, 0, 0, 0,  4, 8'h00, 8'h00, 8'h01, 1};
    tbl[1]  = '{"run40",         0, 0, 0, 0, 36, 8'h00, 8'h00, 8'h10, 1};
    tbl[2]  = '{"hold_min",      1, 0, 1, 0, 10, 8'h00, 8'h01, 8'h10, 0};
    tbl[3]  = '{"hour_edge",     1, 1, 0, 0,  3, 8'h01, 8'h01, 8'h10, 0};
    tbl[4]  = '{"held_hour_clr", 1, 1, 0, 1,  2, 8'h01, 8'h01, 8'h00, 0};
    tbl[5]  = '{"set_idle",      1, 0, 0, 0,  1, 8'h01, 8'h01, 8'h00, 0};
    tbl[6]  = '{"both_edges",    1, 1, 1, 0,  1, 8'h02, 8'h02, 8'h00, 0};
    tbl[7]  = '{"run_first3",    0, 0, 0, 0,  3, 8'h02, 8'h02, 8'h00, 0};
    tbl[8]  = '{"run_tick",      0, 0, 0, 0,  1, 8'h02, 8'h02, 8'h01, 1};
    tbl[9]  = '{"run_ignore",    0, 1, 1, 1,  4, 8'h02, 8'h02, 8'h02, 1};
    tbl[10] = '{"set_held",      1, 1, 1, 0,  1, 8'h02, 8'h02, 8'h02, 0};
    tbl[11] = '{"set_idle2",     1, 0, 0, 0,  1, 8'h02, 8'h02, 8'h02, 0};
    tbl[12] = '{"set_clr",       1, 0, 0, 1,  1, 8'h02, 8'h02, 8'h00, 0};

    model_reset();
    #2;
    check_model();
    steps(2);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].sm, tbl[i].ih, tbl[i].im, tbl[i].cs);
      steps(tbl[i].cyc);
      check({tbl[i].name, ".h"}, hours_bcd, tbl[i].eh);
      check({tbl[i].name, ".m"}, minutes_bcd, tbl[i].em);
      check({tbl[i].name, ".s"}, seconds_bcd, tbl[i].es);
      check({tbl[i].name, ".p"}, {7'd0, sec_pulse}, {7'd0, tbl[i].ep});
    end

    // 61 minute presses from 02:02 wrap once and land on 03; hours untouched.
    pulse_btn(0, 1, 61);
    check("min61.m", minutes_bcd, 8'h03);
    check("min61.h", hours_bcd, 8'h02);

    // Preload 23:59:00 and run 60 ticks across midnight.
    pulse_btn(1, 0, 21);
    pulse_btn(0, 1, 56);
    drive(1, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    steps(239);
    check("pre_wrap.s", seconds_bcd, 8'h59);
    check("pre_wrap.w", {7'd0, day_wrap}, 8'h00);
    step();
    check("wrap.h", hours_bcd, 8'h00);
    check("wrap.m", minutes_bcd, 8'h00);
    check("wrap.s", seconds_bcd, 8'h00);
    check("wrap.p", {7'd0, sec_pulse}, 8'h01);
    check("wrap.w", {7'd0, day_wrap}, 8'h01);
    step();
    check("post_wrap.w", {7'd0, day_wrap}, 8'h00);
    check("post_wrap.p", {7'd0, sec_pulse}, 8'h00);

    // 09:59 with both buttons rising together gives 10:00, no carry.
    pulse_btn(1, 0, 9);
    pulse_btn(0, 1, 59);
    drive(1, 1, 1, 0);
    step();
    check("both.h", hours_bcd, 8'h10);
    check("both.m", minutes_bcd, 8'h00);
    drive(1, 0, 0, 0);
    step();

    // Reach 12:34:56, then reset asynchronously mid-prescale.
    pulse_btn(1, 0, 2);
    pulse_btn(0, 1, 34);
    drive(1, 0, 0, 1);
    step();
    drive(0, 0, 0, 0);
    steps(226);
    check("pre_rst.h", hours_bcd, 8'h12);
    check("pre_rst.m", minutes_bcd, 8'h34);
    check("pre_rst.s", seconds_bcd, 8'h56);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    step();
    #2;
    rst_n = 1'b1;
    steps(3);
    step();
    check("rel.s", seconds_bcd, 8'h01);
    check("rel.p", {7'd0, sec_pulse}, 8'h01);

    // set_mode raised on a tick edge suppresses the advance.
    steps(3);
    drive(1, 0, 0, 0);
    step();
    check("coll.s", seconds_bcd, 8'h01);
    check("coll.p", {7'd0, sec_pulse}, 8'h00);
    steps(2);
    drive(0, 0, 0, 0);
    steps(3);
    check("resume3.s", seconds_bcd, 8'h01);
    step();
    check("resume4.s", seconds_bcd, 8'h02);
    check("resume4.p", {7'd0, sec_pulse}, 8'h01);

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
      inc_hour = ($urandom_range(0, 2) == 0);
      inc_min  = ($urandom_range(0, 2) == 0);
      clr_sec  = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
